mem_bus_seq: RTL
================

# mem_bus_seq

Multi-cycle memory-bus sequencer for the MSP430 core. It steps each instruction through the required memory phases: fetch, extension words, source read, destination read, execute, writeback, push. Each phase drives the MAB select, read/write strobes and latch enables that the instruction decoder and datapath consume. It replaces ad-hoc "done" latching with one explicit FSM gated by a memory ready handshake.

## Interface
- TIMEOUT, 15: max wait cycles for `mem_rdy` in any memory state before `bus_err`
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- mem_rdy  in  1  memory completes the current access this cycle
- fmt  in  2  decoded format: 1=I, 2=II, 3=Jump, 0=illegal
- as_mode  in  2  source As field
- ad_mode  in  1  destination Ad bit (format I only)
- src_cg  in  1  source is constant generator (R2/R3 with As>0)
- src_imm  in  1  As=11 with source PC (immediate)
- dst_rd  in  1  instruction needs destination operand read (not MOV)
- no_wb  in  1  CMP/BIT/PUSH: no destination writeback
- is_push  in  1  PUSH instruction
- sr_upd  in  1  instruction updates SR flags
- jmp_taken  in  1  jump condition true (valid in EXEC)
- mab_sel  out  3  0=PC, 1=Sout, 2=CALC, 3=SP, 4=MDB
- mem_rd, mem_wr  out  1  bus read / write request
- ir_load  out  1  latch MDB into instruction register
- pc_inc  out  1  PC += 2
- pc_load  out  1  load jump target into PC
- src_ext_we, dst_ext_we  out  1  latch extension word (src / dst)
- op_a_we, op_b_we  out  1  latch source / destination operand from MDB
- an_inc  out  1  autoincrement source register (+1 byte, +2 word)
- reg_we, sr_we, sp_dec  out  1  register file, SR, SP-decrement enables
- bus_err  out  1  one-cycle pulse on timeout
- state  out  4  current state, debug

## Operation
- States: RST(0), FETCH(1), DECODE(2), SRC_EXT(3), SRC_RD(4), DST_EXT(5), DST_RD(6), EXEC(7), DST_WR(8), PUSH_WR(9).
- RST: all outputs 0, next FETCH unconditionally.
- FETCH: mab_sel=0, mem_rd. On mem_rdy: ir_load, pc_inc, next DECODE.
- DECODE: no bus activity. fmt=3 or 0 -> EXEC (fmt 0 executes as NOP). Else if !src_cg and (as_mode=01 or src_imm) -> SRC_EXT. Else if !src_cg and as_mode[1] -> SRC_RD. Else if ad_mode -> DST_EXT. Else -> EXEC.
- SRC_EXT: mab_sel=0, mem_rd. On mem_rdy: src_ext_we, pc_inc. src_imm -> (ad_mode ? DST_EXT : EXEC). Otherwise -> SRC_RD.
- SRC_RD: mem_rd. mab_sel=2 for as_mode=01, else 1. On mem_rdy: op_a_we; an_inc if as_mode=11. Next ad_mode ? DST_EXT : EXEC.
- DST_EXT: mab_sel=0, mem_rd. On mem_rdy: dst_ext_we, pc_inc. Next dst_rd ? DST_RD : EXEC.
- DST_RD: mab_sel=2, mem_rd. On mem_rdy: op_b_we, next EXEC.
- EXEC, one cycle:
  - reg_we = !ad_mode & !no_wb & fmt!=3.
  - sr_we = sr_upd.
  - pc_load = (fmt=3) & jmp_taken.
  - sp_dec = is_push.
  - Next: is_push -> PUSH_WR; ad_mode & !no_wb -> DST_WR; else FETCH.
- DST_WR: mab_sel=2, mem_wr, to FETCH on mem_rdy. PUSH_WR: mab_sel=3, mem_wr, to FETCH on mem_rdy.
- Wait states: in any memory state with mem_rdy=0, hold state and all outputs. Latch enables (ir_load, *_we, pc_inc, an_inc) assert only in the mem_rdy cycle.
- Timeout: 4-bit wait counter, cleared on state change. At count=TIMEOUT with mem_rdy=0: pulse bus_err, abandon the access, go to FETCH, assert no latch enables.
- In non-memory states, mab_sel=0 and mem_rd=mem_wr=0.

## Timing
- Reset: state=RST and all outputs 0 while rst high, asynchronously. First FETCH is the cycle after rst deasserts.
- Zero-wait-state minimum cycle counts:
  - Register-mode format I: 3 cycles (FETCH, DECODE, EXEC).
  - Jump: 3 cycles.
  - Indexed src + indexed dst ADD: 7 cycles, +1 for DST_WR = 8.
  - PUSH Rn: 4 cycles.
- mem_rdy sampled on the same posedge that leaves the state. Single-cycle memory means each memory state lasts 1 cycle.
- rst mid-instruction: immediate return to RST, and any pending write is dropped (mem_wr falls asynchronously).
- Decoder inputs are required stable from DECODE through the end of the instruction. IR changes only on ir_load.

## Structure
- Shared package/header (msp430_ops.vh): state encodings, MAB_* select constants, FMT_* constants.
- Single flat module. The timeout counter stays inline; no sub-module.

## Test plan
- Reset then MOV R4,R5 (fmt=1, as=00, ad=0), mem_rdy=1: states 1,2,7,1. reg_we=1 only in EXEC. pc_inc pulses once.
- ADD 2(R4),4(R5) with dst_rd=1: states 1,2,3,4,5,6,7,8. mab_sel sequence 0,-,0,2,0,2,-,2. pc_inc 3 times. mem_wr in state 8.
- MOV @R6+,R7 with 2 wait states in SRC_RD: SRC_RD held 3 cycles with mab_sel=1. op_a_we and an_inc each pulse once, in the third cycle.
- PUSH #0x1234 (src_imm, is_push): SRC_EXT latches immediate. EXEC asserts sp_dec. PUSH_WR drives mab_sel=3, mem_wr.
- JNZ with jmp_taken=1: pc_load=1 in EXEC. With jmp_taken=0: pc_load=0. reg_we=0 in both cases.
- mem_rdy stuck 0 in FETCH: bus_err pulses after 15 wait cycles, FSM restarts FETCH. Assert rst mid-DST_WR: mem_wr drops the same cycle, state=0.

Source files
------------

// File: rtl/mem_bus_seq_pkg.sv
// mem_bus_seq_pkg: shared encodings for the MSP430 memory-bus sequencer.
// State, MAB select and format codes used by the sequencer and decoder.
package mem_bus_seq_pkg;

  typedef enum logic [3:0] {
    ST_RST     = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_SRC_EXT = 4'd3,
    ST_SRC_RD  = 4'd4,
    ST_DST_EXT = 4'd5,
    ST_DST_RD  = 4'd6,
    ST_EXEC    = 4'd7,
    ST_DST_WR  = 4'd8,
    ST_PUSH_WR = 4'd9
  } state_t;

  localparam logic [2:0] MAB_PC   = 3'd0;
  localparam logic [2:0] MAB_SRC  = 3'd1;
  localparam logic [2:0] MAB_CALC = 3'd2;
  localparam logic [2:0] MAB_SP   = 3'd3;
  localparam logic [2:0] MAB_MDB  = 3'd4;

  localparam logic [1:0] FMT_ILL = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_II  = 2'd2;
  localparam logic [1:0] FMT_JMP = 2'd3;

  function automatic logic is_mem(input state_t s);
    return (s == ST_FETCH)   || (s == ST_SRC_EXT) ||
           (s == ST_SRC_RD)  || (s == ST_DST_EXT) ||
           (s == ST_DST_RD)  || (s == ST_DST_WR)  ||
           (s == ST_PUSH_WR);
  endfunction

endpackage

// File: rtl/mem_bus_seq.sv
// mem_bus_seq: per-instruction memory phase sequencer for the MSP430 core.
// One FSM walks fetch/ext/read/exec/write phases, gated by mem_rdy.
module mem_bus_seq
  import mem_bus_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_rdy,
  input  logic [1:0] fmt,
  input  logic [1:0] as_mode,
  input  logic       ad_mode,
  input  logic       src_cg,
  input  logic       src_imm,
  input  logic       dst_rd,
  input  logic       no_wb,
  input  logic       is_push,
  input  logic       sr_upd,
  input  logic       jmp_taken,
  output logic [2:0] mab_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       src_ext_we,
  output logic       dst_ext_we,
  output logic       op_a_we,
  output logic       op_b_we,
  output logic       an_inc,
  output logic       reg_we,
  output logic       sr_we,
  output logic       sp_dec,
  output logic       bus_err,
  output logic [3:0] state
);

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mem_st;
  logic       tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state  = state_q;
  assign mem_st = is_mem(state_q);
  assign tmo    = mem_st & ~mem_rdy & (cnt_q == TMO);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mab_sel    = MAB_PC;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    src_ext_we = 1'b0;
    dst_ext_we = 1'b0;
    op_a_we    = 1'b0;
    op_b_we    = 1'b0;
    an_inc     = 1'b0;
    reg_we     = 1'b0;
    sr_we      = 1'b0;
    sp_dec     = 1'b0;
    bus_err    = 1'b0;

    unique case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Illegal formats fall through EXEC as a NOP.
        if (fmt == FMT_JMP || fmt == FMT_ILL)
          state_d = ST_EXEC;
        else if (!src_cg && (as_mode == 2'b01 || src_imm))
          state_d = ST_SRC_EXT;
        else if (!src_cg && as_mode[1])
          state_d = ST_SRC_RD;
        else if (ad_mode)
          state_d = ST_DST_EXT;
        else
          state_d = ST_EXEC;
      end
      ST_SRC_EXT: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          src_ext_we = 1'b1;
          pc_inc     = 1'b1;
          if (src_imm)
            state_d = ad_mode ? ST_DST_EXT : ST_EXEC;
          else
            state_d = ST_SRC_RD;
        end
      end
      ST_SRC_RD: begin
        mem_rd  = 1'b1;
        mab_sel = (as_mode == 2'b01) ? MAB_CALC : MAB_SRC;
        if (mem_rdy) begin
          op_a_we = 1'b1;
          an_inc  = (as_mode == 2'b11);
          state_d = ad_mode ? ST_DST_EXT : ST_EXEC;
        end
      end
      ST_DST_EXT: begin
        mem_rd = 1'b1;
        if (mem_rdy) begin
          dst_ext_we = 1'b1;
          pc_inc     = 1'b1;
          state_d    = dst_rd ? ST_DST_RD : ST_EXEC;
        end
      end
      ST_DST_RD: begin
        mem_rd  = 1'b1;
        mab_sel = MAB_CALC;
        if (mem_rdy) begin
          op_b_we = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        reg_we  = ~ad_mode & ~no_wb & (fmt != FMT_JMP);
        sr_we   = sr_upd;
        pc_load = (fmt == FMT_JMP) & jmp_taken;
        sp_dec  = is_push;
        if (is_push)
          state_d = ST_PUSH_WR;
        else if (ad_mode && !no_wb)
          state_d = ST_DST_WR;
        else
          state_d = ST_FETCH;
      end
      ST_DST_WR: begin
        mem_wr  = 1'b1;
        mab_sel = MAB_CALC;
        if (mem_rdy) state_d = ST_FETCH;
      end
      ST_PUSH_WR: begin
        mem_wr  = 1'b1;
        mab_sel = MAB_SP;
        if (mem_rdy) state_d = ST_FETCH;
      end
      default: state_d = ST_RST;
    endcase

    // Abandoned access: restart at FETCH with no latch enables.
    if (tmo) begin
      bus_err = 1'b1;
      state_d = ST_FETCH;
    end

    if (tmo || state_d != state_q)
      cnt_d = 4'd0;
    else if (mem_st && !mem_rdy)
      cnt_d = cnt_q + 4'd1;
  end

endmodule
